// File: rtl/shot_magazine_ctrl_if.sv
// ---------------------------------------------------------------------------
// shot_magazine_ctrl_if
//
// Groups the signals between the player input decoder / shot generators and
// the magazine controller.
//
//   fire_req     decoder -> ctrl   level; every sampled-high cycle is a request
//   reload_req   decoder -> ctrl   manual reload request
//   shot_enable  ctrl -> shots     one-hot, one-cycle pulse; bit k = slot k
//   shots_left   ctrl -> shots     rounds remaining in the magazine
//   empty        ctrl -> shots     shots_left == 0
//   reloading    ctrl -> shots     high while a reload is running
//   reload_done  ctrl -> shots     one-cycle pulse when the magazine refills
//
// Modports: master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface shot_magazine_ctrl_if #(
   parameter int MAG_SIZE = 8
);
   localparam int CW = $clog2(MAG_SIZE + 1);

   logic                fire_req;
   logic                reload_req;
   logic [MAG_SIZE-1:0] shot_enable;
   logic [CW-1:0]       shots_left;
   logic                empty;
   logic                reloading;
   logic                reload_done;

   modport master (
      output fire_req,
      output reload_req,
      input  shot_enable,
      input  shots_left,
      input  empty,
      input  reloading,
      input  reload_done
   );

   modport slave (
      input  fire_req,
      input  reload_req,
      output shot_enable,
      output shots_left,
      output empty,
      output reloading,
      output reload_done
   );
endinterface

// File: rtl/shot_magazine_ctrl.sv
// ---------------------------------------------------------------------------
// shot_magazine_ctrl
//
// Magazine controller for the player's shot stack. Grants fire requests as
// one-hot slot pulses, enforces a cooldown between shots and runs a timed
// reload (automatic on empty, or manual / partial on request).
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    shot_magazine_ctrl_if.slave
//            fire_req, reload_req               (in)
//            shot_enable, shots_left, empty,
//            reloading, reload_done             (out)
//
// Parameters:
//   MAG_SIZE         rounds per magazine (2..64)
//   RELOAD_CYCLES    cycles spent reloading (>= 1)
//   COOLDOWN_CYCLES  cycles of blocked fire after each shot (0 = none)
//   AUTO_RELOAD      1 = reload starts by itself when the magazine empties
// ---------------------------------------------------------------------------
module shot_magazine_ctrl #(
   parameter int MAG_SIZE        = 8,
   parameter int RELOAD_CYCLES   = 16,
   parameter int COOLDOWN_CYCLES = 4,
   parameter int AUTO_RELOAD     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   shot_magazine_ctrl_if.slave   bus
);

   localparam int CW     = $clog2(MAG_SIZE + 1);
   localparam int TMAX_A = (RELOAD_CYCLES > COOLDOWN_CYCLES) ? RELOAD_CYCLES : COOLDOWN_CYCLES;
   localparam int TMAX   = (TMAX_A > 2) ? TMAX_A : 2;
   localparam int TW     = $clog2(TMAX);

   localparam logic [CW-1:0] FULL        = CW'(MAG_SIZE);
   localparam logic [TW-1:0] RELOAD_LOAD = TW'(RELOAD_CYCLES - 1);
   // Guarded so a zero cooldown never produces a negative load value.
   localparam logic [TW-1:0] COOL_LOAD   = TW'((COOLDOWN_CYCLES > 0) ? (COOLDOWN_CYCLES - 1) : 0);

   typedef enum logic [1:0] {
      READY     = 2'd0,
      COOLDOWN  = 2'd1,
      EMPTY     = 2'd2,
      RELOADING = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [TW-1:0]       timer;
   logic [TW-1:0]       timer_nxt;
   logic [CW-1:0]       shots_left;
   logic [CW-1:0]       shots_left_nxt;
   logic [MAG_SIZE-1:0] shot_enable;
   logic [MAG_SIZE-1:0] shot_enable_nxt;
   logic                reload_done;
   logic                reload_done_nxt;
   logic [CW-1:0]       slot;
   logic                can_reload;

   // Decode a slot index into a one-hot shot_enable pattern.
   function automatic logic [MAG_SIZE-1:0] slot_onehot(input logic [CW-1:0] idx);
      logic [MAG_SIZE-1:0] r;
      for (int k = 0; k < MAG_SIZE; k++) begin
         r[k] = (idx == CW'(k));
      end
      return r;
   endfunction

   // The next round to leave is counted from the front of the magazine, so a
   // full magazine fires slot 0 first and slot MAG_SIZE-1 last.
   assign slot       = FULL - shots_left;
   // A manual reload only makes sense when at least one round is missing.
   assign can_reload = bus.reload_req && (shots_left != FULL);

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= READY;
         timer       <= '0;
         shots_left  <= FULL;
         shot_enable <= '0;
         reload_done <= 1'b0;
      end else begin
         state       <= state_nxt;
         timer       <= timer_nxt;
         shots_left  <= shots_left_nxt;
         shot_enable <= shot_enable_nxt;
         reload_done <= reload_done_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt       = state;
      timer_nxt       = timer;
      shots_left_nxt  = shots_left;
      shot_enable_nxt = '0;
      reload_done_nxt = 1'b0;

      case (state)
         READY: begin
            // Fire has priority over a simultaneous reload request.
            if (bus.fire_req) begin
               shot_enable_nxt = slot_onehot(slot);
               shots_left_nxt  = shots_left - CW'(1);
               if (shots_left == CW'(1)) begin
                  if (AUTO_RELOAD != 0) begin
                     state_nxt = RELOADING;
                     timer_nxt = RELOAD_LOAD;
                  end else begin
                     state_nxt = EMPTY;
                     timer_nxt = '0;
                  end
               end else if (COOLDOWN_CYCLES > 0) begin
                  state_nxt = COOLDOWN;
                  timer_nxt = COOL_LOAD;
               end
            end else if (can_reload) begin
               state_nxt = RELOADING;
               timer_nxt = RELOAD_LOAD;
            end
         end

         COOLDOWN: begin
            // Fire requests are dropped here; a reload aborts the cooldown.
            if (can_reload) begin
               state_nxt = RELOADING;
               timer_nxt = RELOAD_LOAD;
            end else if (timer == '0) begin
               state_nxt = READY;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end

         EMPTY: begin
            if (bus.reload_req) begin
               state_nxt = RELOADING;
               timer_nxt = RELOAD_LOAD;
            end
         end

         RELOADING: begin
            // All requests are ignored until the refill edge; a fire sampled
            // on that edge is not granted because the state is still RELOADING.
            if (timer == '0) begin
               state_nxt       = READY;
               shots_left_nxt  = FULL;
               reload_done_nxt = 1'b1;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end

         default: begin
            state_nxt = READY;
            timer_nxt = '0;
         end
      endcase
   end

   assign bus.shot_enable = shot_enable;
   assign bus.shots_left  = shots_left;
   assign bus.empty       = (shots_left == '0);
   assign bus.reloading   = (state == RELOADING);
   assign bus.reload_done = reload_done;

endmodule

// File: tb/tb_shot_magazine_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shot_magazine_ctrl
//
// Three controllers run side by side:
//   d0: defaults (cooldown 4, auto reload)
//   d1: cooldown 0, auto reload
//   d2: cooldown 4, manual reload only
// A behavioural model (rounds / cooldown-left / reload-left counters) is
// compared against every controller on each falling edge; directed phases
// add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_shot_magazine_ctrl;

   localparam int MAG = 8;
   localparam int REL = 16;
   localparam int COOL_OF [3] = '{4, 0, 4};
   localparam int AUTO_OF [3] = '{1, 1, 0};

   logic clk = 1'b0;
   logic reset;
   logic fire_v [3];
   logic rel_v  [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shot_magazine_ctrl_if #(.MAG_SIZE(MAG)) bus0 ();
   shot_magazine_ctrl_if #(.MAG_SIZE(MAG)) bus1 ();
   shot_magazine_ctrl_if #(.MAG_SIZE(MAG)) bus2 ();

   assign bus0.fire_req   = fire_v[0];
   assign bus0.reload_req = rel_v[0];
   assign bus1.fire_req   = fire_v[1];
   assign bus1.reload_req = rel_v[1];
   assign bus2.fire_req   = fire_v[2];
   assign bus2.reload_req = rel_v[2];

   shot_magazine_ctrl #(.MAG_SIZE(MAG), .RELOAD_CYCLES(REL), .COOLDOWN_CYCLES(4), .AUTO_RELOAD(1))
      dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
   shot_magazine_ctrl #(.MAG_SIZE(MAG), .RELOAD_CYCLES(REL), .COOLDOWN_CYCLES(0), .AUTO_RELOAD(1))
      dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
   shot_magazine_ctrl #(.MAG_SIZE(MAG), .RELOAD_CYCLES(REL), .COOLDOWN_CYCLES(4), .AUTO_RELOAD(0))
      dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

   logic [7:0] se  [3];
   logic [3:0] sl  [3];
   logic       emp [3];
   logic       rld [3];
   logic       dn  [3];

   assign se[0] = bus0.shot_enable;  assign sl[0] = bus0.shots_left;  assign emp[0] = bus0.empty;
   assign rld[0] = bus0.reloading;   assign dn[0] = bus0.reload_done;
   assign se[1] = bus1.shot_enable;  assign sl[1] = bus1.shots_left;  assign emp[1] = bus1.empty;
   assign rld[1] = bus1.reloading;   assign dn[1] = bus1.reload_done;
   assign se[2] = bus2.shot_enable;  assign sl[2] = bus2.shots_left;  assign emp[2] = bus2.empty;
   assign rld[2] = bus2.reloading;   assign dn[2] = bus2.reload_done;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_rounds [3];
   int         m_cool   [3];   // cycles of blocked fire still to come
   int         m_rl     [3];   // reload cycles still to come
   logic [7:0] m_en     [3];
   logic       m_done   [3];

   always @(posedge clk or posedge reset) begin
      for (int d = 0; d < 3; d++) begin
         if (reset) begin
            m_rounds[d] = MAG;
            m_cool[d]   = 0;
            m_rl[d]     = 0;
            m_en[d]     = 8'h00;
            m_done[d]   = 1'b0;
         end else begin
            m_en[d]   = 8'h00;
            m_done[d] = 1'b0;
            if (m_rl[d] > 0) begin
               m_rl[d] = m_rl[d] - 1;
               if (m_rl[d] == 0) begin
                  m_rounds[d] = MAG;
                  m_done[d]   = 1'b1;
               end
            end else if (m_rounds[d] == 0) begin
               if (rel_v[d]) m_rl[d] = REL;
            end else if (m_cool[d] > 0) begin
               if (rel_v[d] && m_rounds[d] < MAG) begin
                  m_rl[d]   = REL;
                  m_cool[d] = 0;
               end else begin
                  m_cool[d] = m_cool[d] - 1;
               end
            end else if (fire_v[d]) begin
               m_en[d]     = 8'(1 << (MAG - m_rounds[d]));
               m_rounds[d] = m_rounds[d] - 1;
               if (m_rounds[d] == 0) begin
                  if (AUTO_OF[d] != 0) m_rl[d] = REL;
               end else begin
                  m_cool[d] = COOL_OF[d];
               end
            end else if (rel_v[d] && m_rounds[d] < MAG) begin
               m_rl[d] = REL;
            end
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         check($sformatf("d%0d shot_enable", d), int'(se[d]), int'(m_en[d]));
         check($sformatf("d%0d shots_left", d), int'(sl[d]), m_rounds[d]);
         check($sformatf("d%0d empty", d), int'(emp[d]), int'(m_rounds[d] == 0));
         check($sformatf("d%0d reloading", d), int'(rld[d]), int'(m_rl[d] > 0));
         check($sformatf("d%0d reload_done", d), int'(dn[d]), int'(m_done[d]));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         fire_v[d] = 1'b0;
         rel_v[d]  = 1'b0;
      end
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int grants;
      int dones;
      int highs;
      logic prev_done;

      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         fire_v[d] = 1'b0;
         rel_v[d]  = 1'b0;
      end
      #2 reset = 1'b1;
      step();
      check("reset shots_left", int'(sl[0]), 8);
      check("reset shot_enable", int'(se[0]), 0);
      check("reset reloading", int'(rld[0]), 0);
      reset = 1'b0;

      // Phase 1: fire held high for 60 cycles, cooldown 4, auto reload.
      do_reset();
      fire_v[0] = 1'b1;
      grants = 0; dones = 0; highs = 0; prev_done = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (i == 1) begin
            check("p1 first grant", int'(se[0]), 1);
            check("p1 first shots_left", int'(sl[0]), 7);
         end
         if (i == 36) check("p1 last grant bit7", int'(se[0]), 8'h80);
         if (prev_done) check("p1 bit0 after refill", int'(se[0]), 1);
         if (se[0] != 0) grants++;
         if (dn[0]) dones++;
         if (rld[0]) highs++;
         prev_done = dn[0];
      end
      fire_v[0] = 1'b0;
      check("p1 grant count", grants, 10);
      check("p1 reload_done count", dones, 1);
      check("p1 reloading cycles", highs, 16);

      // Phase 2: zero cooldown, back-to-back grants.
      do_reset();
      fire_v[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("p2 walk", int'(se[1]), 1 << i);
      end
      step();
      check("p2 reloading after empty", int'(rld[1]), 1);
      fire_v[1] = 1'b0;

      // Phase 3: three shots, reload during cooldown.
      do_reset();
      fire_v[0] = 1'b1;
      repeat (11) step();
      fire_v[0] = 1'b0;
      check("p3 shots_left after 3", int'(sl[0]), 5);
      step();
      rel_v[0] = 1'b1;
      step();
      rel_v[0] = 1'b0;
      check("p3 reloading entered", int'(rld[0]), 1);
      check("p3 partial count kept", int'(sl[0]), 5);
      repeat (15) step();
      check("p3 still reloading", int'(rld[0]), 1);
      step();
      check("p3 reload_done", int'(dn[0]), 1);
      check("p3 refilled", int'(sl[0]), 8);

      // Phase 4: reload request with a full magazine is ignored.
      do_reset();
      rel_v[0] = 1'b1;
      repeat (3) step();
      rel_v[0] = 1'b0;
      check("p4 no reload", int'(rld[0]), 0);
      check("p4 no done", int'(dn[0]), 0);
      check("p4 full", int'(sl[0]), 8);

      // Phase 5: manual-only reload holds in EMPTY.
      do_reset();
      fire_v[2] = 1'b1;
      grants = 0;
      repeat (56) begin
         step();
         if (se[2] != 0) grants++;
      end
      fire_v[2] = 1'b0;
      check("p5 grants", grants, 8);
      check("p5 empty", int'(emp[2]), 1);
      check("p5 shots_left", int'(sl[2]), 0);
      check("p5 not reloading", int'(rld[2]), 0);
      rel_v[2] = 1'b1;
      step();
      rel_v[2] = 1'b0;
      check("p5 reload start", int'(rld[2]), 1);
      repeat (15) step();
      check("p5 still reloading", int'(rld[2]), 1);
      step();
      check("p5 reload_done", int'(dn[2]), 1);
      check("p5 refilled", int'(sl[2]), 8);

      // Phase 6: fire and reload together with 5 rounds left.
      do_reset();
      fire_v[0] = 1'b1;
      repeat (11) step();
      fire_v[0] = 1'b0;
      repeat (4) step();
      fire_v[0] = 1'b1;
      rel_v[0]  = 1'b1;
      step();
      fire_v[0] = 1'b0;
      rel_v[0]  = 1'b0;
      check("p6 bit3 fires", int'(se[0]), 8'h08);
      check("p6 shots_left", int'(sl[0]), 4);
      check("p6 no reload", int'(rld[0]), 0);
      step();
      check("p6 still no reload", int'(rld[0]), 0);

      // Phase 7: reset in the middle of a reload.
      do_reset();
      fire_v[0] = 1'b1;
      step();
      fire_v[0] = 1'b0;
      repeat (4) step();
      rel_v[0] = 1'b1;
      step();
      rel_v[0] = 1'b0;
      repeat (6) step();
      check("p7 reloading before reset", int'(rld[0]), 1);
      reset = 1'b1;
      #1;
      check("p7 async shots_left", int'(sl[0]), 8);
      check("p7 async reloading", int'(rld[0]), 0);
      check("p7 async shot_enable", int'(se[0]), 0);
      check("p7 async reload_done", int'(dn[0]), 0);
      step();
      step();
      reset = 1'b0;
      dones = 0;
      repeat (20) begin
         step();
         if (dn[0]) dones++;
      end
      check("p7 no reload_done after abort", dones, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shot_magazine_ctrl.md
Name: shot_magazine_ctrl

Overview:
Parametrised magazine controller for the player's shot stack.
- Tracks the rounds left and grants fire requests as one-hot slot pulses.
- Enforces a cooldown between shots.
- Runs a timed reload, either automatically on empty or on a manual request that also allows a partial reload.
- Emits a single-cycle reload-done pulse to the shot-stack logic.
- Sits between the player input decoder and the shot object generators.

Parameters:
- MAG_SIZE, 8, rounds per magazine; legal range 2..64; width of shot_enable.
- RELOAD_CYCLES, 16, number of clock cycles spent in RELOADING; must be ≥1.
- COOLDOWN_CYCLES, 4, number of cycles after each granted shot during which fire is blocked; 0 disables cooldown.
- AUTO_RELOAD, 1, 1 = reload starts automatically when the magazine empties; 0 = wait for reload_req.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- fire_req  in  1  level; sampled every edge; each sampled-high cycle is one request.
- reload_req  in  1  manual reload request; sampled every edge.
- shot_enable  out  MAG_SIZE  registered one-hot pulse, 1 cycle; bit k = slot k fired.
- shots_left  out  clog2(MAG_SIZE+1)  registered round count.
- empty  out  1  shots_left == 0; combinational from register.
- reloading  out  1  high while state is RELOADING.
- reload_done  out  1  registered 1-cycle pulse when the magazine refills.

Behaviour:
- Reset (async assert, any state, including mid-reload or mid-cooldown):
  - state = READY, shots_left = MAG_SIZE.
  - shot_enable = 0, reload_done = 0, timer = 0.
  - A reload in progress is aborted; no reload_done is emitted.
- States: READY, COOLDOWN, EMPTY, RELOADING. A single timer is shared by COOLDOWN and RELOADING.
- READY, fire_req = 1 at edge N (shots_left > 0 is guaranteed in READY):
  - At edge N: shot_enable[MAG_SIZE − shots_left] = 1 for one cycle, and shots_left decrements.
  - Result: the first shot of a full magazine is bit 0, the last is bit MAG_SIZE−1.
  - Next state:
    - if the new shots_left = 0: RELOADING when AUTO_RELOAD = 1, else EMPTY;
    - else if COOLDOWN_CYCLES > 0: COOLDOWN, with timer loaded to COOLDOWN_CYCLES−1;
    - else: READY (back-to-back shots every cycle).
- READY, reload_req = 1 with fire_req = 0:
  - If shots_left < MAG_SIZE: go to RELOADING (partial reload).
  - If shots_left = MAG_SIZE: request ignored.
- READY, fire_req and reload_req together: fire wins and reload_req is dropped. Requests are never latched or queued.
- COOLDOWN:
  - fire_req is dropped.
  - reload_req is accepted under the same rule as READY, and aborts the cooldown.
  - Timer decrements each cycle; at timer = 0 the next edge goes to READY.
  - State lasts exactly COOLDOWN_CYCLES cycles.
- EMPTY (only reachable with AUTO_RELOAD = 0):
  - fire_req is ignored.
  - reload_req moves to RELOADING.
- RELOADING:
  - Entry loads timer = RELOAD_CYCLES−1; reloading = 1.
  - fire_req and reload_req are ignored.
  - Timer decrements each cycle; when timer = 0, the next edge sets shots_left = MAG_SIZE, reload_done = 1 and state = READY.
  - reloading is high for exactly RELOAD_CYCLES cycles.
  - reload_done is high in the first READY cycle only.
  - A fire_req sampled at that same edge is not granted; the first grant is possible at the following edge.
- Timer width: clog2(max(RELOAD_CYCLES, COOLDOWN_CYCLES, 2)). The timer never wraps; it is reloaded on every state entry.
- Invariants:
  - shot_enable is at most one-hot.
  - shot_enable and reload_done are never high in the same cycle.
  - shots_left never underflows below 0 or exceeds MAG_SIZE.

Test Plan (MAG_SIZE = 8, RELOAD_CYCLES = 16, COOLDOWN_CYCLES = 4 unless noted):
- Reset released, fire_req held high for 60 cycles, AUTO_RELOAD = 1:
  - shot_enable walks bits 0..7 with a grant every 5 cycles;
  - shots_left steps 8→0; reloading is high for 16 cycles;
  - reload_done pulses once, and bit 0 fires again on the following edge.
- COOLDOWN_CYCLES = 0, fire_req held high: 8 consecutive-cycle grants (bits 0..7), then RELOADING.
- Fire 3 shots, then pulse reload_req during COOLDOWN: RELOADING entered on that edge; after 16 cycles shots_left = 8 and reload_done = 1.
- reload_req with a full magazine: no state change, reloading stays 0, no reload_done.
- AUTO_RELOAD = 0: empty the magazine; state holds in EMPTY with empty = 1 and further fire_req ignored for 20 cycles; reload_req then starts a 16-cycle reload.
- fire_req and reload_req high together in READY with shots_left = 5: bit 3 fires, shots_left = 4, no reload started.
- Assert reset at cycle 7 of a reload: all outputs clear and shots_left = 8 immediately; no reload_done pulse follows.
